// File: rtl/hex_loader_pkg.sv
// rtl/hex_loader_pkg.sv - shared types, character constants and decode helpers for the hex loader
package hex_loader_pkg;

  typedef enum logic [2:0] {
    ST_SOL,
    ST_SLASH,
    ST_SKIP,
    ST_ADDR,
    ST_SEP,
    ST_DATA,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_EOT   = 8'h04;
  localparam logic [7:0] CH_AT    = 8'h40;
  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_CR    = 8'h0D;

  // ASCII 0-9, a-f, A-F
  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h61) && (c <= 8'h66)) ||
           ((c >= 8'h41) && (c <= 8'h46));
  endfunction

  // Letters a-f/A-F have low nibble 1..6, so adding 9 yields 10..15
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    if (c <= 8'h39) return c[3:0];
    else            return c[3:0] + 4'd9;
  endfunction

  // Byte enables for one 32-bit lane within a word of up to 128 bits
  function automatic logic [15:0] lane_be(input logic [1:0] lane);
    return 16'h000F << {lane, 2'b00};
  endfunction

endpackage

// File: rtl/hex_digit_decode.sv
// rtl/hex_digit_decode.sv - ASCII byte to hex nibble decoder
module hex_digit_decode
  import hex_loader_pkg::*;
(
  input  logic [7:0] data,
  output logic       valid,
  output logic [3:0] nibble
);

  // Pure combinational classification of one input byte
  always_comb begin
    valid  = is_hex(data);
    nibble = hex_val(data);
  end

endmodule

// File: rtl/hex_mem_loader.sv
// rtl/hex_mem_loader.sv - .mem text stream parser producing boot-memory word writes
module hex_mem_loader
  import hex_loader_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 11,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          CNT_W     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic                  o_rx_ready,
  output logic                  o_mem_we,
  input  logic                  i_mem_ready,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_be,
  output logic                  o_done,
  output logic [CNT_W-1:0]      o_line_count,
  output logic [CNT_W-1:0]      o_word_count,
  output logic [CNT_W-1:0]      o_err_count
);

  localparam int L     = $clog2(DATA_W / 8);
  localparam int SPAN  = ADDR_W + L;
  localparam int LANES = DATA_W / 32;
  localparam int BE_W  = DATA_W / 8;
  localparam logic [1:0] LANE_MASK = 2'(LANES - 1);

  state_t              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [27:0]         data_q, data_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                ws_q, ws_d;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic [CNT_W-1:0]    line_q, word_q, err_q;

  logic        hex_ok;
  logic [3:0]  nib;
  logic        accept, is_nl, is_ws, is_eot;
  logic        err_ev, word_ev, line_ev, load_wr;
  logic [32:0] off;
  logic        range_ok;
  logic [31:0] data_shift;
  logic [1:0]  lane;

  hex_digit_decode u_dec (
    .data   (i_rx_data),
    .valid  (hex_ok),
    .nibble (nib)
  );

  assign o_rx_ready   = (state_q != ST_WRITE) && (state_q != ST_DONE);
  assign o_mem_we     = (state_q == ST_WRITE);
  assign o_done       = (state_q == ST_DONE);
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_mem_be     = be_q;
  assign o_line_count = line_q;
  assign o_word_count = word_q;
  assign o_err_count  = err_q;

  // Next-state decode: one byte per cycle, errors reported once per line
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    ws_d       = ws_q;
    err_ev     = 1'b0;
    word_ev    = 1'b0;
    load_wr    = 1'b0;
    accept     = i_rx_valid && o_rx_ready;
    is_nl      = (i_rx_data == CH_NL);
    is_eot     = (i_rx_data == CH_EOT);
    is_ws      = (i_rx_data == CH_SP) || (i_rx_data == CH_TAB) || (i_rx_data == CH_CR);
    line_ev    = accept && is_nl;
    data_shift = {data_q, nib};
    off        = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    range_ok   = (addr_q[1:0] == 2'b00) && !off[32] && ((off[31:0] >> SPAN) == 32'd0);
    lane       = off[3:2] & LANE_MASK;

    if (state_q == ST_WRITE) begin
      if (i_mem_ready) begin
        word_ev = 1'b1;
        state_d = ST_SKIP;
      end
    end else if (accept) begin
      if (is_eot) begin
        state_d = ST_DONE;
      end else begin
        case (state_q)
          ST_SOL: begin
            if (is_ws || is_nl) state_d = ST_SOL;
            else if (i_rx_data == CH_SLASH) state_d = ST_SLASH;
            else if (i_rx_data == CH_AT) begin
              state_d = ST_ADDR;
              cnt_d   = 3'd0;
            end else begin
              err_ev  = 1'b1;
              state_d = ST_SKIP;
            end
          end
          ST_SLASH: begin
            if (i_rx_data == CH_SLASH) state_d = ST_SKIP;
            else begin
              err_ev  = 1'b1;
              state_d = is_nl ? ST_SOL : ST_SKIP;
            end
          end
          ST_SKIP: begin
            if (is_nl) state_d = ST_SOL;
          end
          ST_ADDR: begin
            if (hex_ok) begin
              addr_d = {addr_q[27:0], nib};
              cnt_d  = cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                state_d = ST_SEP;
                ws_d    = 1'b0;
              end
            end else begin
              err_ev  = 1'b1;
              state_d = is_nl ? ST_SOL : ST_SKIP;
            end
          end
          ST_SEP: begin
            if (is_ws) ws_d = 1'b1;
            else if (hex_ok && ws_q) begin
              state_d = ST_DATA;
              data_d  = data_shift[27:0];
              cnt_d   = 3'd1;
            end else begin
              err_ev  = 1'b1;
              state_d = is_nl ? ST_SOL : ST_SKIP;
            end
          end
          ST_DATA: begin
            if (hex_ok) begin
              data_d = data_shift[27:0];
              cnt_d  = cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                if (range_ok) begin
                  load_wr = 1'b1;
                  state_d = ST_WRITE;
                end else begin
                  err_ev  = 1'b1;
                  state_d = ST_SKIP;
                end
              end
            end else begin
              err_ev  = 1'b1;
              state_d = is_nl ? ST_SOL : ST_SKIP;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  // State, parse registers, write-port registers and saturating counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_SOL;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      ws_q       <= 1'b0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      line_q     <= '0;
      word_q     <= '0;
      err_q      <= '0;
    end else if (i_clear) begin
      state_q <= ST_SOL;
      line_q  <= '0;
      word_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ws_q    <= ws_d;
      if (load_wr) begin
        mem_addr_q <= off[SPAN-1:L];
        wdata_q    <= {LANES{data_shift}};
        be_q       <= BE_W'(lane_be(lane));
      end
      if (line_ev && (line_q != '1)) line_q <= line_q + CNT_W'(1);
      if (word_ev && (word_q != '1)) word_q <= word_q + CNT_W'(1);
      if (err_ev  && (err_q  != '1)) err_q  <= err_q  + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hex_mem_loader.sv
// tb/tb_hex_mem_loader.sv - directed self-checking bench for hex_mem_loader
module tb_hex_mem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic [2:0] rxv = 3'b000;
  logic [2:0] mr  = 3'b111;
  logic [2:0] rdy;
  logic [7:0] rxd [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // instance a: 32-bit, base 0
  logic        a_we, a_done;
  logic [10:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_be;
  logic [15:0] a_line, a_word, a_err;
  // instance b: 128-bit
  logic         b_we, b_done;
  logic [10:0]  b_addr;
  logic [127:0] b_wdata;
  logic [15:0]  b_be;
  logic [15:0]  b_line, b_word, b_err;
  // instance c: 32-bit, 16 words at 0x1000
  logic        c_we, c_done;
  logic [3:0]  c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_be;
  logic [15:0] c_line, c_word, c_err;

  hex_mem_loader u_a (
    .i_clk(clk), .i_rst(rst), .i_clear(clear),
    .i_rx_valid(rxv[0]), .i_rx_data(rxd[0]), .o_rx_ready(rdy[0]),
    .o_mem_we(a_we), .i_mem_ready(mr[0]), .o_mem_addr(a_addr),
    .o_mem_wdata(a_wdata), .o_mem_be(a_be), .o_done(a_done),
    .o_line_count(a_line), .o_word_count(a_word), .o_err_count(a_err)
  );

  hex_mem_loader #(.DATA_W(128)) u_b (
    .i_clk(clk), .i_rst(rst), .i_clear(clear),
    .i_rx_valid(rxv[1]), .i_rx_data(rxd[1]), .o_rx_ready(rdy[1]),
    .o_mem_we(b_we), .i_mem_ready(mr[1]), .o_mem_addr(b_addr),
    .o_mem_wdata(b_wdata), .o_mem_be(b_be), .o_done(b_done),
    .o_line_count(b_line), .o_word_count(b_word), .o_err_count(b_err)
  );

  hex_mem_loader #(.DATA_W(32), .ADDR_W(4), .BASE_ADDR(32'h1000)) u_c (
    .i_clk(clk), .i_rst(rst), .i_clear(clear),
    .i_rx_valid(rxv[2]), .i_rx_data(rxd[2]), .o_rx_ready(rdy[2]),
    .o_mem_we(c_we), .i_mem_ready(mr[2]), .o_mem_addr(c_addr),
    .o_mem_wdata(c_wdata), .o_mem_be(c_be), .o_done(c_done),
    .o_line_count(c_line), .o_word_count(c_word), .o_err_count(c_err)
  );

  // write loggers: record each completed write handshake
  int a_wn = 0, b_wn = 0, c_wn = 0;
  logic [31:0]  a_wa = '0, b_wa = '0, c_wa = '0;
  logic [127:0] a_wd = '0, b_wd = '0, c_wd = '0;
  logic [15:0]  a_wb = '0, b_wb = '0, c_wb = '0;

  always @(posedge clk) begin
    if (a_we && mr[0]) begin a_wn <= a_wn + 1; a_wa <= 32'(a_addr); a_wd <= 128'(a_wdata); a_wb <= 16'(a_be); end
    if (b_we && mr[1]) begin b_wn <= b_wn + 1; b_wa <= 32'(b_addr); b_wd <= b_wdata;        b_wb <= b_be;      end
    if (c_we && mr[2]) begin c_wn <= c_wn + 1; c_wa <= 32'(c_addr); c_wd <= 128'(c_wdata); c_wb <= 16'(c_be); end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // present one byte at a negedge, wait (bounded) for ready, return at the negedge after acceptance
  task automatic send(input int s, input logic [7:0] b);
    int n;
    n = 0;
    rxv[s] = 1'b1;
    rxd[s] = b;
    while (!rdy[s]) begin
      if (n == 100) begin
        total++;
        bad++;
        $error("FAIL send_timeout: observed ready=0 expected ready=1 (inst %0d)", s);
        break;
      end
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rxv[s] = 1'b0;
  endtask

  task automatic send_str(input int s, input string str);
    for (int i = 0; i < str.len(); i++) send(s, str[i]);
  endtask

  initial begin
    rxd[0] = 8'h00; rxd[1] = 8'h00; rxd[2] = 8'h00;
    repeat (2) @(negedge clk);

    // reset values
    chk("rst_rdy",   128'(rdy[0]), 128'd1);
    chk("rst_we",    128'(a_we), 128'd0);
    chk("rst_addr",  128'(a_addr), 128'd0);
    chk("rst_wdata", 128'(a_wdata), 128'd0);
    chk("rst_be",    128'(b_be), 128'd0);
    chk("rst_done",  128'(a_done), 128'd0);
    chk("rst_cnts",  {80'd0, a_line, a_word, a_err}, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic 32-bit record
    send_str(0, "@00000010 DEADBEEF\n");
    chk("a1_wn",    128'(a_wn), 128'd1);
    chk("a1_addr",  128'(a_wa), 128'd4);
    chk("a1_be",    128'(a_wb), 128'hF);
    chk("a1_wdata", a_wd, 128'hDEADBEEF);
    chk("a1_word",  128'(a_word), 128'd1);
    chk("a1_line",  128'(a_line), 128'd1);
    chk("a1_err",   128'(a_err), 128'd0);

    // comment, blank, junk and misaligned lines
    send_str(0, "// x\n");
    send_str(0, "\n");
    send_str(0, "#bad\n");
    send_str(0, "@00000012 11111111\n");
    chk("a2_wn",   128'(a_wn), 128'd1);
    chk("a2_line", 128'(a_line), 128'd5);
    chk("a2_err",  128'(a_err), 128'd2);
    chk("a2_word", 128'(a_word), 128'd1);

    // 128-bit lanes with a stalled write
    mr[1] = 1'b0;
    send_str(1, "@00000014 12345678");
    for (int k = 0; k < 3; k++) begin
      chk("b_we_hold",  128'(b_we), 128'd1);
      chk("b_rdy_hold", 128'(rdy[1]), 128'd0);
      chk("b_be_hold",  128'(b_be), 128'h00F0);
      if (k < 2) @(negedge clk);
    end
    chk("b_addr_hold", 128'(b_addr), 128'd1);
    chk("b_wdata_hold", b_wdata, {4{32'h12345678}});
    mr[1] = 1'b1;
    @(negedge clk);
    chk("b_we_rel",  128'(b_we), 128'd0);
    chk("b_rdy_rel", 128'(rdy[1]), 128'd1);
    chk("b1_wn",     128'(b_wn), 128'd1);
    chk("b1_addr",   128'(b_wa), 128'd1);
    chk("b1_be",     128'(b_wb), 128'h00F0);
    send_str(1, "\n");
    send_str(1, "@0000001C 9ABCDEF0\n");
    chk("b2_wn",    128'(b_wn), 128'd2);
    chk("b2_addr",  128'(b_wa), 128'd1);
    chk("b2_be",    128'(b_wb), 128'hF000);
    chk("b2_wdata", b_wd, {4{32'h9ABCDEF0}});
    chk("b2_word",  128'(b_word), 128'd2);

    // range checks against a nonzero base
    send_str(2, "@00000FFC 00000001\n");
    send_str(2, "@00001040 00000002\n");
    chk("c_err_only", 128'(c_wn), 128'd0);
    send_str(2, "@0000103C 0000CAFE\n");
    chk("c_wn",    128'(c_wn), 128'd1);
    chk("c_addr",  128'(c_wa), 128'd15);
    chk("c_be",    128'(c_wb), 128'hF);
    chk("c_wdata", c_wd, 128'h0000CAFE);
    chk("c_err",   128'(c_err), 128'd2);
    chk("c_line",  128'(c_line), 128'd3);
    chk("c_word",  128'(c_word), 128'd1);

    // EOT inside a data field, then clear
    send_str(0, "@00000020 1234");
    send(0, 8'h04);
    chk("eot_done", 128'(a_done), 128'd1);
    chk("eot_rdy",  128'(rdy[0]), 128'd0);
    chk("eot_wn",   128'(a_wn), 128'd1);
    chk("eot_we",   128'(a_we), 128'd0);
    chk("eot_err",  128'(a_err), 128'd2);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_done", 128'(a_done), 128'd0);
    chk("clr_rdy",  128'(rdy[0]), 128'd1);
    chk("clr_cnts", {80'd0, a_line, a_word, a_err}, 128'd0);
    send_str(0, "@00000008 00000077\n");
    chk("clr_wn",   128'(a_wn), 128'd2);
    chk("clr_addr", 128'(a_wa), 128'd2);
    chk("clr_word", 128'(a_word), 128'd1);
    chk("clr_line", 128'(a_line), 128'd1);

    // asynchronous reset during a stalled write
    mr[0] = 1'b0;
    send_str(0, "@00000004 0000AAAA");
    chk("ar_we_pre", 128'(a_we), 128'd1);
    #1 rst = 1'b1;
    #1 chk("ar_we_async", 128'(a_we), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    mr[0] = 1'b1;
    chk("ar_rdy",  128'(rdy[0]), 128'd1);
    chk("ar_done", 128'(a_done), 128'd0);
    chk("ar_cnts", {80'd0, a_line, a_word, a_err}, 128'd0);
    chk("ar_wn",   128'(a_wn), 128'd2);
    send_str(0, "\n");
    chk("ar_line", 128'(a_line), 128'd1);
    chk("ar_err",  128'(a_err), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_mem_loader.md
# hex_mem_loader

Synthesizable successor to the simulation-only boot-memory file reader. It parses a `.mem`-format text byte stream (for example from the UART RX path) and turns it into word writes into boot memory, at any power-of-two memory width. Each record has the form `@AAAAAAAA DDDDDDDD`. For 128-bit (A25) memories, a 32-bit record goes into the correct lane using byte enables, with no read-modify-write. It sits between the byte source and the boot-memory write port, and runs once per boot load.

## Interface
Parameters:
- `DATA_W`, default 32: memory word width; 32, 64 or 128.
- `ADDR_W`, default 11: memory word-index width.
- `BASE_ADDR`, default 32'h0: byte address of memory word 0.
- `CNT_W`, default 16: width of the status counters.

Ports:
- `i_clk` in 1: the single clock.
- `i_rst` in 1: asynchronous reset, active-high.
- `i_clear` in 1: synchronous clear of the counters; returns the parser to SOL.
- `i_rx_valid` in 1: input byte valid.
- `i_rx_data` in 8: input byte (ASCII).
- `o_rx_ready` out 1: byte is accepted when `i_rx_valid && o_rx_ready`.
- `o_mem_we` out 1: write request, held until accepted.
- `i_mem_ready` in 1: memory accepts the write this cycle.
- `o_mem_addr` out ADDR_W: word index.
- `o_mem_wdata` out DATA_W: the 32-bit record data replicated across all lanes.
- `o_mem_be` out DATA_W/8: byte enables for the selected 32-bit lane.
- `o_done` out 1: EOT byte (8'h04) received; sticky.
- `o_line_count`, `o_word_count`, `o_err_count` out CNT_W each: saturating counters.

## Operation
- Character classes:
  - Hex: 0-9, a-f, A-F.
  - Whitespace: 8'h20, 8'h09, 8'h0D.
  - Newline: 8'h0A.
  - EOT: 8'h04.
- States: SOL, SLASH, SKIP, ADDR, SEP, DATA, WRITE, DONE.
- SOL:
  - Whitespace → stay.
  - Newline → stay.
  - `'/'` → SLASH.
  - `'@'` → ADDR, clearing the digit count.
  - Any other byte → error, SKIP.
- SLASH:
  - `'/'` → SKIP (comment line).
  - Newline → error, SOL.
  - Any other byte → error, SKIP.
- SKIP: consume bytes until a newline, then SOL.
- ADDR: shift 8 hex digits into the address register, MSB first. A non-hex byte before 8 digits → error; go to SOL if the byte was a newline, otherwise SKIP. After the 8th digit → SEP.
- SEP:
  - Needs at least one whitespace byte; the first hex digit after that → DATA, counted as digit 1.
  - Hex with no preceding whitespace → error, SKIP.
  - Newline → error, SOL.
- DATA: 8 hex digits, same error rule as ADDR. After the 8th digit:
  - Range/alignment check: offset = addr − BASE_ADDR. The record is an error if `addr[1:0] != 0`, or offset < 0, or offset ≥ 2^(ADDR_W+log2(DATA_W/8)).
  - Pass → WRITE.
  - Fail → error, SKIP.
- WRITE:
  - `o_mem_we=1`.
  - `o_mem_addr = offset[ADDR_W+L-1:L]`, where L = log2(DATA_W/8).
  - lane = `offset[L-1:2]`; `o_mem_be = 4'hF << (4*lane)`. For DATA_W=32, `o_mem_be=4'hF`.
  - On `i_mem_ready`: increment word count, go to SKIP (trailing text on the line is ignored).
- EOT in any state except WRITE → DONE. Any partial record is discarded; not an error.
- DONE: `o_rx_ready=0` until `i_clear` or `i_rst`.
- Counters:
  - Line count increments on every accepted newline.
  - Error count increments once per offending line.
  - All counters saturate at all-ones.
- `i_clear` has priority over byte acceptance in the same cycle: it zeroes the counters, clears `o_done`, and moves to SOL.

## Timing
- Reset values:
  - `o_rx_ready=1`, state SOL.
  - `o_mem_we=0`, `o_mem_addr=0`, `o_mem_wdata=0`, `o_mem_be=0`.
  - `o_done=0`, all counters 0.
- Throughput: one byte per cycle in every parse state. `o_rx_ready=0` only in WRITE and DONE.
- Write latency: 8th data digit accepted at edge N → `o_mem_we` high, with address/data/be stable, from N+1. Held until the first edge where `i_mem_ready=1`. `o_rx_ready` returns high the cycle after that.
- `o_mem_we` and the other write outputs change only at state entry or exit.
- `i_rst` asserted mid-WRITE drops `o_mem_we` asynchronously; the write is lost.
- Counter and `o_done` updates are visible the cycle after the triggering accept.

## Structure
- Package `hex_loader_pkg` holds:
  - the state enum;
  - character constants (NL, EOT, AT, SLASH);
  - the `is_hex`/`hex_val` decode function;
  - the `lane_be` function.
- One sub-module, `hex_digit_decode`: byte in → valid flag plus 4-bit nibble.
- Single always_ff for state, registers and counters; combinational next-state logic separate.

## Test plan
- DATA_W=32, stream `"@00000010 DEADBEEF\n"` → one write: addr=4, be=4'hF, wdata=32'hDEADBEEF; word=1, line=1, err=0.
- DATA_W=128, records at 0x00000014 and 0x0000001C with i_mem_ready held low for 3 cycles → writes at addr=1 with be=16'h00F0, then addr=1 with be=16'hF000. `o_mem_we` held for 3 cycles, no byte accepted while held.
- Lines `"// x\n"`, `"\n"`, `"#bad\n"`, `"@00000012 11111111\n"` (misaligned) → no writes, line=4, err=2.
- BASE_ADDR=32'h1000, ADDR_W=4: records at 0x0FFC and 0x1040 → both errors. Record at 0x103C → write at addr=15.
- EOT in the middle of a DATA field → no write, o_done=1, o_rx_ready=0. Then i_clear → counters 0, parsing resumes at SOL.
- Assert i_rst during WRITE → o_mem_we low immediately. After release: state SOL, all counters 0.
